// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner:
//               scan state enum, default column dwell, key-map table and
//               small lookup helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DWELL_DEFAULT = 4;

  // Nibble {row,col} (row in the upper two bits) holds the key code.
  // Row 0: 1 2 3 A, row 1: 4 5 6 B, row 2: 7 8 9 C, row 3: E 0 F D.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [3:0] idx;
    idx = {row, col};
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

  // Rows are active-low; the lowest-index low row wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Keypad matrix and key-report signals.
//               rows        - raw active-low row lines (keypad -> scanner)
//               cols        - active-low one-hot column drive
//               key_code    - hex code of the detected key
//               key_pressed - high while the detected key is held
//               master: keypad/consumer side, slave: scanner side.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  modport master (output rows, input cols, key_code, key_pressed);
  modport slave  (input rows, output cols, key_code, key_pressed);
endinterface
`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for asynchronous level inputs.
//               Ports: clk, reset (sync, active-low), d_i (async input),
//               q_o (synchronized output). Flops reset to all ones, which
//               matches the idle (pulled-up) level of the keypad rows.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               samples the synchronized rows once per DWELL cycles and
//               locks onto the first key found until that key's row is
//               released. No debouncing is done here.
//               Ports: clk, reset (sync, active-low),
//                      kp (slave modport: rows in; cols, key_code,
//                          key_pressed out).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.slave  kp
);

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  logic [3:0] rows_s;
  logic [7:0] cnt_q, cnt_d;
  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] held_row_q, held_row_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_pressed_q, key_pressed_d;
  logic       sample;
  logic [1:0] row_sel;
  logic [3:0] key_map_out;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (kp.rows),
    .q_o   (rows_s)
  );

  assign sample = (cnt_q == CNT_LAST);

  // While scanning the candidate row is the lowest low row seen now; once
  // holding, the latched row is what selects the key.
  assign row_sel     = (state_q == HOLD) ? held_row_q : lowest_low(rows_s);
  assign key_map_out = key_lookup(row_sel, col_q);

  always_comb begin
    cnt_d = sample ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q         <= 8'd0;
      state_q       <= SCAN;
      col_q         <= 2'd0;
      held_row_q    <= 2'd0;
      key_code_q    <= 4'hF;
      key_pressed_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      col_q         <= col_d;
      held_row_q    <= held_row_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    held_row_d    = held_row_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (rows_s == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            held_row_d    = row_sel;
            key_code_d    = key_map_out;
            key_pressed_d = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          // Only the latched row matters; other rows in this column are
          // ignored until it goes high again.
          if (rows_s[held_row_q]) begin
            key_pressed_d = 1'b0;
            col_d         = col_q + 2'd1;
            state_d       = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign kp.cols        = ~(4'b0001 << col_q);
  assign kp.key_code    = key_code_q;
  assign kp.key_pressed = key_pressed_q;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DWELL, default 4, clock cycles each column is driven before its rows are sampled; legal range 3..255.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 rows  input  4  raw keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-005 cols  output  4  keypad column drive, active-low one-hot (exactly one bit 0 at all times).
REQ-006 key_code  output  4  hex code of the detected key; feeds the downstream debouncer's 4-bit data input.
REQ-007 key_pressed  output  1  high while a key is held on the scanned matrix; feeds the debouncer's key-press input.

Function
REQ-008 rows SHALL pass through a two-flop synchronizer before any use; internal logic sees only rows_s.
REQ-009 An 8-bit dwell counter SHALL count 0..DWELL-1 then wrap to 0; the sample point is the cycle with count == DWELL-1.
REQ-010 States SHALL be SCAN and HOLD.
REQ-011 SCAN: at each sample point, if rows_s == 4'b1111 the active column SHALL advance 0->1->2->3->0 (cols 1110->1101->1011->0111->1110), effective the next cycle.
REQ-012 SCAN: at a sample point with any rows_s bit low, the block SHALL latch held_row = lowest-index low row, keep the current column, register key_code, assert key_pressed, and enter HOLD, all effective the next cycle.
REQ-013 Several rows low in one column: the lowest row index wins; other columns are not examined until release.
REQ-014 HOLD: cols SHALL stay fixed; at each sample point, if rows_s[held_row] == 1 the block SHALL deassert key_pressed, advance to the next column, and return to SCAN, effective the next cycle; otherwise it remains in HOLD.
REQ-015 HOLD: presses on other rows of the held column SHALL be ignored.
REQ-016 Key map (row r, col c) -> key_code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-017 key_code SHALL hold its last value after release; it changes only on a SCAN->HOLD transition.
REQ-018 Worst-case detection latency from a stable press to key_pressed high SHALL be 4*DWELL+3 cycles.
REQ-019 The block performs no debouncing; a bounce visible at a sample point SHALL produce a release and re-detect, which the downstream stage filters.

Reset
REQ-020 While reset == 0 at posedge clk: state = SCAN, column = 0 (cols = 4'b1110), dwell counter = 0, key_code = 4'hF, key_pressed = 0, synchronizer flops = 4'b1111.
REQ-021 Reset asserted mid-HOLD SHALL drop key_pressed the following cycle; a still-held key SHALL be re-detected by normal scanning after release of reset.
REQ-022 There is no asynchronous reset path.

Structure
REQ-023 Package keypad_pkg SHALL hold the state enum (SCAN, HOLD), the DWELL default, and the 16-entry key-map constant.
REQ-024 The two-flop synchronizer SHALL be a separate sub-module, sync2, parameterized by width (here 4).
REQ-025 The key-map lookup SHALL be combinational from {held_row, column}; counter, state, column and outputs are registered.

Verification
REQ-026 Reset, then rows = 1111 for 40 cycles -> cols cycles 1110,1101,1011,0111 with each value held 4 cycles; key_pressed stays 0; key_code stays F.
REQ-027 Hold row1/col2 low whenever col2 is driven -> within 19 cycles key_pressed = 1, key_code = 6, cols frozen at 1011; release -> key_pressed = 0 within DWELL+3 cycles and scanning resumes at col3; key_code stays 6.
REQ-028 Press row0 and row3 in col1 together -> key_code = 2 (row0 wins); release row0 while row3 is still held -> key_pressed = 0, then key_code = 0 is detected on the next pass through col1.
REQ-029 Key r3/c0 held, reset pulsed low for 1 cycle mid-HOLD -> key_pressed = 0 and cols = 1110 the next cycle; key_code = E is re-asserted after the synchronizer fills and the next sample point is reached.
REQ-030 Glitch: row2 low for 1 cycle, away from a sample point, while col0 is driven -> no detection, key_pressed stays 0.
REQ-031 All 16 keys pressed in turn -> key_code matches the REQ-016 map for each; a fresh reset is not required between presses.
